// File: rtl/cluster_event_token_reader.sv
// cluster_event_token_reader: cluster-side read end of the SoC->cluster token-ring event FIFO
module cluster_event_token_reader #(
  parameter  int BUFFER_WIDTH = 8,
  parameter  int EVNT_WIDTH   = 8,
  parameter  int SYNC_STAGES  = 2,
  localparam int IW = (BUFFER_WIDTH > 1) ? $clog2(BUFFER_WIDTH) : 1,
  localparam int PW = $clog2(BUFFER_WIDTH + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [BUFFER_WIDTH-1:0] events_wt_i,
  output logic [BUFFER_WIDTH-1:0] events_rp_o,
  input  logic [EVNT_WIDTH-1:0]   events_da_i,
  output logic                    evt_valid_o,
  input  logic                    evt_ready_i,
  output logic [EVNT_WIDTH-1:0]   evt_data_o,
  output logic [PW-1:0]           evt_pending_o
);
  typedef enum logic [1:0] {IDLE, CAPTURE, WAIT_ACK} state_t;
  state_t                  r_state, w_next;
  logic [BUFFER_WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [BUFFER_WIDTH-1:0] r_rp, w_wt_s, w_diff;
  logic [IW-1:0]           r_idx;
  logic [PW-1:0]           r_pend, w_cnt;
  logic [EVNT_WIDTH-1:0]   r_data;
  logic                    r_valid, w_full, w_hs;
  assign w_wt_s        = r_sync[SYNC_STAGES-1];
  assign w_diff        = w_wt_s ^ r_rp;
  assign w_full        = w_diff[r_idx];
  assign w_hs          = r_valid && evt_ready_i;
  assign events_rp_o   = r_rp;
  assign evt_valid_o   = r_valid;
  assign evt_data_o    = r_data;
  assign evt_pending_o = r_pend;
  // plain flop chain: the token bus is gray-like, so each bit settles independently
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sync <= '{default: '0};
    end else begin
      r_sync[0] <= events_wt_i;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
    end
  end
  always_comb begin
    w_cnt = '0;
    for (int b = 0; b < BUFFER_WIDTH; b++) w_cnt = w_cnt + PW'(w_diff[b]);
  end
  always_comb begin
    w_next = IDLE;
    w_next = (r_state == IDLE)     ? (w_full ? CAPTURE : IDLE) :
             (r_state == CAPTURE)  ? WAIT_ACK :
             (r_state == WAIT_ACK) ? (w_hs ? (w_full ? CAPTURE : IDLE) : WAIT_ACK) : IDLE;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_next;
  end
  // data is sampled a cycle after the slot was seen full, so the writer's mux has settled
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rp    <= '0;
      r_idx   <= '0;
      r_pend  <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      r_pend <= w_cnt;
      if (r_state == CAPTURE) begin
        r_data       <= events_da_i;
        r_valid      <= 1'b1;
        r_rp[r_idx]  <= ~r_rp[r_idx];
        r_idx        <= (r_idx == IW'(BUFFER_WIDTH-1)) ? '0 : r_idx + 1'b1;
      end else if (w_hs) begin
        r_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_cluster_event_token_reader.sv
// tb_cluster_event_token_reader: scoreboard bench with a behavioural SoC writer model
module tb_cluster_event_token_reader;
  localparam int BW = 8;
  logic          clk = 1'b0, rst = 1'b1, ready = 1'b0;
  logic [BW-1:0] wt = '0, rp;
  logic [7:0]    da, data;
  logic          valid;
  logic [3:0]    pending;
  logic [7:0]    mem [BW];
  logic [7:0]    q [$];
  int            n_chk = 0, n_fail = 0, cyc = 0, last_hs = -1;
  logic          gap_chk = 1'b0;
  logic          p_rst = 1'b1, p_valid = 1'b0, p_ready = 1'b0;
  logic [BW-1:0] p_rp = '0;
  logic [7:0]    p_data = '0;

  cluster_event_token_reader dut (
    .clk_i(clk), .rst_i(rst), .events_wt_i(wt), .events_rp_o(rp), .events_da_i(da),
    .evt_valid_o(valid), .evt_ready_i(ready), .evt_data_o(data), .evt_pending_o(pending)
  );

  always #5 clk = ~clk;

  function automatic int nxt_slot(input logic [BW-1:0] p);
    nxt_slot = 0;
    for (int i = BW - 1; i >= 1; i--) if (p[i] != p[0]) nxt_slot = i;
  endfunction

  always_comb da = mem[nxt_slot(rp)];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!rst && !p_rst) begin
      check("rp_one_bit_change", 32'($countones(rp ^ p_rp) <= 1), 1);
      if (p_valid && !p_ready) check("hold_stable", {valid, data}, {1'b1, p_data});
    end
    if (!rst && valid && ready) begin
      if (q.size() == 0) check("spurious_event", 1, 0);
      else check("event_data", data, q.pop_front());
      if (gap_chk && last_hs >= 0) check("hs_spacing", cyc - last_hs, 2);
      last_hs = cyc;
    end
    p_rst = rst; p_valid = valid; p_ready = ready; p_rp = rp; p_data = data;
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; wt = '0; q.delete(); gap_chk = 1'b0; last_hs = -1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic wr(input int slot, input logic [7:0] val);
    mem[slot] = val;
    wt[slot]  = ~wt[slot];
    q.push_back(val);
  endtask

  task automatic wait_drain(input string tag, input int max);
    int n = 0;
    while (q.size() != 0 && n < max) begin
      @(negedge clk);
      n++;
    end
    check(tag, q.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < BW; i++) mem[i] = '0;
    // 1: single event latency
    do_reset();
    @(negedge clk);
    check("rst_valid", valid, 0);
    check("rst_data", data, 0);
    check("rst_rp", rp, 0);
    @(posedge clk); #1;
    ready = 1'b1;
    wr(0, 8'hA5);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("lat_valid_early", valid, 0);
    @(negedge clk);
    check("lat_valid", valid, 1);
    check("lat_data", data, 8'hA5);
    check("lat_rp", rp, 8'h01);
    @(negedge clk);
    check("lat_pending", pending, 0);
    check("lat_valid_drop", valid, 0);
    // 2: backpressure then release
    do_reset();
    ready = 1'b0;
    wr(0, 8'h11); wr(1, 8'h22); wr(2, 8'h33);
    repeat (8) @(negedge clk);
    check("bp_valid", valid, 1);
    check("bp_data", data, 8'h11);
    check("bp_pending", pending, 2);
    @(posedge clk); #1;
    gap_chk = 1'b1; last_hs = -1; ready = 1'b1;
    wait_drain("bp_drain", 30);
    gap_chk = 1'b0;
    // 3: stream 10 events through the ring
    do_reset();
    ready = 1'b1;
    begin
      int wp = 0, n = 0, t = 0;
      while (n < 10 && t < 400) begin
        @(posedge clk); #1;
        t++;
        if (wt[wp] == rp[wp]) begin
          wr(wp, 8'($urandom_range(0, 255)));
          wp = (wp + 1) % BW;
          n++;
        end
      end
      check("stream_written", n, 10);
    end
    wait_drain("stream_drain", 60);
    repeat (3) @(negedge clk);
    check("stream_rp", rp, 8'hFC);
    check("stream_pending", pending, 0);
    // 4: full ring from reset
    do_reset();
    for (int i = 0; i < BW; i++) wr(i, 8'(8'h40 + i * 3));
    wt = 8'hFF; ready = 1'b1; gap_chk = 1'b1; last_hs = -1;
    begin
      int n = 0;
      while (pending != 8 && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    check("full_pending", pending, 8);
    wait_drain("full_drain", 40);
    gap_chk = 1'b0;
    repeat (3) @(negedge clk);
    check("full_rp", rp, 8'hFF);
    // 5: reset while an event is held
    do_reset();
    ready = 1'b0;
    wr(0, 8'h5A); wr(1, 8'h6B); wr(2, 8'h7C); wr(3, 8'h8D);
    begin
      int n = 0;
      while (!(valid && pending == 3) && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    check("pre_rst_valid", valid, 1);
    check("pre_rst_pending", pending, 3);
    @(posedge clk); #1;
    rst = 1'b1; wt = '0; q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", valid, 0);
    check("mid_rst_rp", rp, 0);
    check("mid_rst_data", data, 0);
    repeat (6) @(negedge clk);
    check("post_rst_idle", valid, 0);
    check("post_rst_pending", pending, 0);
    check("post_rst_rp", rp, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
